// File: rtl/dot_product_ctrl.sv
// dot_product_ctrl
//   Sequencer for the dot-product vector memory. On start it walks two stored
//   vectors element by element over the memory's single read port (A then B
//   per element), multiply-accumulates them and offers the scalar result on a
//   valid/ready output.
//
//   Ports
//     clk, rst              clock (rising edge), async active-high reset
//     start                 request; sampled only while idle
//     vec_a_sel, vec_b_sel  operand vector indices, latched on start
//     busy                  high whenever not idle
//     mem_rd_en/addr        read port request (Moore outputs of RD_A / RD_B)
//     mem_rd_data           read data, valid one cycle after mem_rd_en
//     result/result_valid   dot product, held until result_ready at an edge
//     result_ready          consumer accept
//
//   Build option
//     DOTP_SIGNED_EN        elements are two's complement, products
//                           sign-extended, result signed. Undefined: unsigned.
module dot_product_ctrl #(
  parameter int DATA_WIDTH        = 8,
  parameter int NUMBER_OF_VECTORS = 4,
  parameter int VEC_LEN           = 8,
  parameter int ADDR_WIDTH        = 5,
  parameter int SEL_WIDTH         = 2,
  parameter int ACC_WIDTH         = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  vec_a_sel,
  input  logic [SEL_WIDTH-1:0]  vec_b_sel,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready
);

  localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int PW    = 2 * DATA_WIDTH;

  // Vectors must fit in the address space.
  if (NUMBER_OF_VECTORS * VEC_LEN > (1 << ADDR_WIDTH)) begin : g_bad_cfg
    $error("dot_product_ctrl: vectors do not fit in ADDR_WIDTH");
  end

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, DONE} state_e;

  state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]  a_sel_q, a_sel_d, b_sel_q, b_sel_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] a_reg_q, a_reg_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d, result_q, result_d;
  logic                  result_valid_q, result_valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ACC_WIDTH-1:0]  prod_ext, acc_sum;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;

`ifdef DOTP_SIGNED_EN
  logic signed [PW-1:0] prod;
  assign prod = $signed(a_reg_q) * $signed(mem_rd_data);
`else
  logic [PW-1:0] prod;
  assign prod = a_reg_q * mem_rd_data;
`endif

  // Size cast extends according to prod's signedness.
  assign prod_ext = ACC_WIDTH'(prod);
  assign acc_sum  = acc_q + prod_ext;

  assign a_addr = ADDR_WIDTH'(a_sel_q) * ADDR_WIDTH'(VEC_LEN) + ADDR_WIDTH'(idx_q);
  assign b_addr = ADDR_WIDTH'(b_sel_q) * ADDR_WIDTH'(VEC_LEN) + ADDR_WIDTH'(idx_q);

  always_comb begin
    state_d        = state_q;
    a_sel_d        = a_sel_q;
    b_sel_d        = b_sel_q;
    idx_d          = idx_q;
    a_reg_d        = a_reg_q;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    addr_d         = addr_q;
    mem_rd_en      = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        a_sel_d = vec_a_sel;
        b_sel_d = vec_b_sel;
        acc_d   = '0;
        idx_d   = '0;
        state_d = RD_A;
      end
      RD_A: begin
        mem_rd_en = 1'b1;
        addr_d    = a_addr;
        state_d   = RD_B;
      end
      RD_B: begin
        mem_rd_en = 1'b1;
        addr_d    = b_addr;
        a_reg_d   = mem_rd_data;   // data from the RD_A read
        state_d   = MAC;
      end
      MAC: begin
        acc_d = acc_sum;           // mem_rd_data is the B element here
        if (idx_q == IDX_W'(VEC_LEN - 1)) begin
          result_d       = acc_sum;
          result_valid_d = 1'b1;
          state_d        = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = RD_A;
        end
      end
      DONE: if (result_ready) begin
        result_valid_d = 1'b0;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      a_sel_q        <= '0;
      b_sel_q        <= '0;
      idx_q          <= '0;
      a_reg_q        <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      addr_q         <= '0;
    end else begin
      state_q        <= state_d;
      a_sel_q        <= a_sel_d;
      b_sel_q        <= b_sel_d;
      idx_q          <= idx_d;
      a_reg_q        <= a_reg_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      addr_q         <= addr_d;
    end
  end

  // Address is driven in the read states and otherwise holds the last one.
  assign mem_rd_addr  = addr_d;
  assign busy         = (state_q != IDLE);
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// tb_dot_product_ctrl
//   Randomised + directed bench for dot_product_ctrl. Holds a synchronous-read
//   memory model, a plain-arithmetic dot-product reference and a record of the
//   read addresses issued per run.
module tb_dot_product_ctrl;
  localparam int DW = 8, NV = 4, VL = 8, AW = 5, SW = 2, ACCW = 19;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [SW-1:0]   vec_a_sel, vec_b_sel;
  logic            busy, mem_rd_en, result_valid, result_ready;
  logic [AW-1:0]   mem_rd_addr;
  logic [DW-1:0]   mem_rd_data;
  logic [ACCW-1:0] result;

  logic [DW-1:0]   mem [NV*VL];
  logic [AW-1:0]   addrs [$];
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  dot_product_ctrl #(
    .DATA_WIDTH(DW), .NUMBER_OF_VECTORS(NV), .VEC_LEN(VL),
    .ADDR_WIDTH(AW), .SEL_WIDTH(SW), .ACC_WIDTH(ACCW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .vec_a_sel(vec_a_sel), .vec_b_sel(vec_b_sel),
    .busy(busy), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  // Synchronous read port; also logs every address requested.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_rd_addr];
      addrs.push_back(mem_rd_addr);
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model(input int a, input int b);
    longint s = 0;
    for (int i = 0; i < VL; i++) begin
`ifdef DOTP_SIGNED_EN
      s += longint'($signed(mem[a*VL+i])) * longint'($signed(mem[b*VL+i]));
`else
      s += longint'(mem[a*VL+i]) * longint'(mem[b*VL+i]);
`endif
    end
    return s;
  endfunction

  function automatic longint res_val();
`ifdef DOTP_SIGNED_EN
    return longint'($signed(result));
`else
    return longint'(result);
`endif
  endfunction

  task automatic load_fixed();
    for (int i = 0; i < NV*VL; i++) mem[i] = 8'hA0 + 8'(i);
  endtask

  task automatic run_op(input int a, input int b, input int hold,
                        input int pulse_at, input int idle_wait);
    int edges, bad, seen, stable;
    longint exp, r0;
    exp = model(a, b);
    chk("pre_valid", result_valid, 0);
    @(negedge clk);
    vec_a_sel = SW'(a); vec_b_sel = SW'(b); start = 1'b1;
    result_ready = (hold == 0);
    addrs.delete();
    @(posedge clk); #1 start = 1'b0;
    edges = 0;
    while (!result_valid && edges < 200) begin
      @(posedge clk); edges++; #1;
      start = (edges == pulse_at);
    end
    start = 1'b0;
    chk("latency", edges, 3*VL);
    chk("result", res_val(), exp);
    chk("n_addr", addrs.size(), 2*VL);
    bad = 0;
    for (int i = 0; i < 2*VL && i < addrs.size(); i++)
      if (int'(addrs[i]) != ((i % 2 == 0) ? a : b) * VL + i / 2) bad++;
    chk("addr_seq", bad, 0);
    r0 = res_val();
    stable = 1;
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      if (result_valid !== 1'b1 || res_val() != r0) stable = 0;
    end
    if (hold > 0) chk("hold", stable, 1);
    result_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", result_valid, 0);
    chk("busy_drop", busy, 0);
    seen = 0;
    for (int c = 0; c < idle_wait; c++) begin
      @(posedge clk); #1;
      if (result_valid || busy) seen = 1;
    end
    chk("single_result", seen, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; vec_a_sel = '0; vec_b_sel = '0; result_ready = 1'b1;
    load_fixed();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_en", mem_rd_en, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_addr", mem_rd_addr, 0);
    @(negedge clk) rst = 1'b0;

    run_op(0, 0, 0, 0, 5);    // squared norm
    run_op(0, 1, 0, 0, 5);
    run_op(1, 0, 5, 0, 5);    // consumer stalls
    run_op(0, 1, 0, 10, 30);  // start while busy is ignored

    // Abort a run mid-flight with an async reset between edges.
    @(negedge clk); vec_a_sel = '0; vec_b_sel = '0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #6 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_en", mem_rd_en, 0);
    chk("abort_valid", result_valid, 0);
    chk("abort_result", result, 0);
    @(negedge clk) rst = 1'b0;
    run_op(0, 1, 0, 0, 5);

    // Random contents, operands and stall lengths.
    repeat (8) begin
      for (int i = 0; i < NV*VL; i++) mem[i] = 8'($urandom);
      run_op(int'($urandom_range(NV-1)), int'($urandom_range(NV-1)),
             int'($urandom_range(4)), 0, 2);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
